// File: rtl/ahb_mtx_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mtx_output_arbiter
// Purpose  : Round-robin address-phase arbiter for one AHB matrix output
//            stage, with burst/lock hold and data-phase owner tracking.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_mtx_output_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_in,
  input  logic [NUM_PORTS-1:0] burst_in,
  input  logic [NUM_PORTS-1:0] lock_in,
  input  logic                 HREADYM,
  output logic [NUM_PORTS-1:0] grant,
  output logic [2:0]           addr_in_port,
  output logic                 no_port,
  output logic [2:0]           data_in_port,
  output logic                 data_valid
);

  localparam logic [2:0] C_LAST_RST = 3'(NUM_PORTS - 1);

  logic [2:0] r_owner;
  logic       r_owner_vld;
  logic [2:0] r_last;
  logic [2:0] r_data_port;
  logic       r_data_vld;

  logic       w_hold;
  logic       w_found;
  logic [2:0] w_pick;

  // Hold flags of the current owner; the loop avoids a narrow-index select.
  always_comb begin
    w_hold = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_owner == 3'(i)) begin
        w_hold = r_owner_vld & (lock_in[i] | burst_in[i]);
      end
    end
  end

  // Round-robin search from last+1: lowest requester above last wins,
  // otherwise lowest requester at or below last (wrap-around).
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_in[i] && (i <= int'(r_last))) begin
        w_found = 1'b1;
        w_pick  = 3'(i);
      end
    end
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_in[i] && (i > int'(r_last))) begin
        w_found = 1'b1;
        w_pick  = 3'(i);
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_owner     <= 3'd0;
      r_owner_vld <= 1'b0;
      r_last      <= C_LAST_RST;
      r_data_port <= 3'd0;
      r_data_vld  <= 1'b0;
    end else if (HREADYM) begin
      r_data_port <= r_owner;
      r_data_vld  <= r_owner_vld;
      if (!w_hold) begin
        if (w_found) begin
          r_owner     <= w_pick;
          r_owner_vld <= 1'b1;
          r_last      <= w_pick;
        end else begin
          r_owner_vld <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant[i] = r_owner_vld && (r_owner == 3'(i));
    end
  end

  assign addr_in_port = r_owner;
  assign no_port      = ~r_owner_vld;
  assign data_in_port = r_data_port;
  assign data_valid   = r_data_vld;

endmodule
`default_nettype wire
